// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_transmitter among NUM_REQ byte sources,
// with a launch timeout on tx_busy and a forced idle gap between frames.
module uart_tx_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16,
    parameter int MIN_GAP       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic                 tx_busy,
    output logic                 tx_transmit,
    output logic [7:0]           tx_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   timeout_err,
    output logic                 active
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W  = $clog2(START_TIMEOUT);
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TIMEOUT - 1);
    localparam logic [7:0]       GAP_LAST = 8'(MIN_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SEND,
        S_DONE,
        S_GAP
    } state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [7:0]           gap_cnt_q, gap_cnt_d;
    logic                 xmit_q, xmit_d;
    logic [7:0]           data_q, data_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic                 active_q, active_d;

    logic [PTR_W-1:0]     win;
    logic                 win_found;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int k);
        return PTR_W'((int'(base) + k) % NUM_REQ);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] i);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
    endfunction

    // Search upward from the source after the last one served, wrapping around.
    always_comb begin
        win       = ptr_q;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req[wrap_idx(ptr_q, k)]) begin
                win_found = 1'b1;
                win       = wrap_idx(ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        xmit_d    = xmit_q;
        data_d    = data_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = '0;

        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    owner_d  = win;
                    grant_d  = onehot(win);
                    data_d   = req_data[{win, 3'b000} +: 8];
                    xmit_d   = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (tx_busy) begin
                    xmit_d  = 1'b0;
                    state_d = S_SEND;
                end else if (to_cnt_q == TO_LAST) begin
                    xmit_d    = 1'b0;
                    err_d     = onehot(owner_q);
                    grant_d   = '0;
                    data_d    = '0;
                    ptr_d     = owner_q;
                    gap_cnt_d = '0;
                    state_d   = (MIN_GAP == 0) ? S_IDLE : S_GAP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                // Frame length belongs to the transmitter, so no timeout here.
                if (!tx_busy) begin
                    done_d  = onehot(owner_q);
                    grant_d = '0;
                    data_d  = '0;
                    ptr_d   = owner_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gap_cnt_d = '0;
                state_d   = (MIN_GAP == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= PTR_RST;
            owner_q   <= '0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
            xmit_q    <= 1'b0;
            data_q    <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            xmit_q    <= xmit_d;
            data_q    <= data_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            active_q  <= active_d;
        end
    end

    assign tx_transmit = xmit_q;
    assign tx_data     = data_q;
    assign grant       = grant_q;
    assign done        = done_q;
    assign timeout_err = err_q;
    assign active      = active_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: transmitter bus model, frame-level reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_uart_tx_scheduler;
    localparam int N   = 4;
    localparam int TO  = 16;
    localparam int GAP = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic           tx_busy = 1'b0;
    logic           tx_transmit;
    logic [7:0]     tx_data;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [N-1:0]   timeout_err;
    logic           active;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_scheduler #(.NUM_REQ(N), .START_TIMEOUT(TO), .MIN_GAP(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .tx_busy    (tx_busy),
        .tx_transmit(tx_transmit),
        .tx_data    (tx_data),
        .grant      (grant),
        .done       (done),
        .timeout_err(timeout_err),
        .active     (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transmitter stand-in: busy rises bus_dly cycles after a transmit edge, lasts bus_len.
    bit   bus_en   = 1'b1;
    int   bus_dly  = 2;
    int   bus_len  = 12;
    int   wait_cnt = 0;
    int   hold_cnt = 0;
    int   rises    = 0;
    logic prev_x   = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            tx_busy  = 1'b0;
            wait_cnt = 0;
            hold_cnt = 0;
            prev_x   = 1'b0;
        end else begin
            if (tx_transmit && !prev_x) begin
                rises++;
                if (bus_en) wait_cnt = bus_dly;
            end
            prev_x = tx_transmit;
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    tx_busy  = 1'b1;
                    hold_cnt = bus_len;
                end
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) tx_busy = 1'b0;
            end
        end
    end

    // Reference model: tracks the frame in progress as flags and countdowns.
    int         m_owner = 0;
    int         m_ptr = N - 1;
    int         m_launch_n = 0;
    int         m_gap_left = 0;
    bit         m_launching = 1'b0;
    bit         m_sending = 1'b0;
    bit         m_post_done = 1'b0;
    logic       e_xmit = 1'b0;
    logic [7:0] e_data = '0;
    logic [N-1:0] e_grant = '0;
    logic [N-1:0] e_done = '0;
    logic [N-1:0] e_err = '0;
    logic       e_active = 1'b0;

    task automatic model_step();
        bit found;
        int idx;
        if (!reset) begin
            m_owner = 0; m_ptr = N - 1; m_launch_n = 0; m_gap_left = 0;
            m_launching = 1'b0; m_sending = 1'b0; m_post_done = 1'b0;
            e_xmit = 1'b0; e_data = '0; e_grant = '0; e_done = '0; e_err = '0; e_active = 1'b0;
        end else begin
            e_done = '0;
            e_err  = '0;
            if (m_launching) begin
                if (tx_busy) begin
                    m_launching = 1'b0; m_sending = 1'b1; e_xmit = 1'b0;
                end else if (m_launch_n == TO - 1) begin
                    m_launching = 1'b0; e_xmit = 1'b0; e_err = N'(1) << m_owner;
                    e_grant = '0; e_data = '0; m_ptr = m_owner; m_gap_left = GAP;
                end else begin
                    m_launch_n++;
                end
            end else if (m_sending) begin
                if (!tx_busy) begin
                    m_sending = 1'b0; e_done = N'(1) << m_owner;
                    e_grant = '0; e_data = '0; m_ptr = m_owner; m_post_done = 1'b1;
                end
            end else if (m_post_done) begin
                m_post_done = 1'b0;
                m_gap_left  = GAP;
            end else if (m_gap_left > 0) begin
                m_gap_left--;
            end else begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!found && ((req >> idx) & N'(1)) != '0) begin
                        found = 1'b1; m_owner = idx; e_grant = N'(1) << idx;
                        e_data = 8'(req_data >> (8 * idx)); e_xmit = 1'b1;
                        m_launching = 1'b1; m_launch_n = 0;
                    end
                end
            end
            e_active = m_launching || m_sending || m_post_done || (m_gap_left > 0);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("cyc_tx_transmit", 32'(tx_transmit), 32'(e_xmit));
        check("cyc_tx_data", 32'(tx_data), 32'(e_data));
        check("cyc_grant", 32'(grant), 32'(e_grant));
        check("cyc_done", 32'(done), 32'(e_done));
        check("cyc_timeout_err", 32'(timeout_err), 32'(e_err));
        check("cyc_active", 32'(active), 32'(e_active));
    end

    task automatic wait_grant(input int budget);
        int n = 0;
        while (grant == '0 && n < budget) begin @(negedge clk); n++; end
        check("wait_grant_in_time", 32'(grant != '0), 32'd1);
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while ((done | timeout_err) == '0 && n < budget) begin @(negedge clk); n++; end
        check("wait_end_in_time", 32'((done | timeout_err) != '0), 32'd1);
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!tx_busy && n < budget) begin @(negedge clk); n++; end
        check("wait_busy_in_time", 32'(tx_busy), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (active && n < budget) begin @(negedge clk); n++; end
        check("wait_idle_in_time", 32'(active), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] t2_order [5];
    int n;
    int r0;

    initial begin
        t2_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_tx_transmit", 32'(tx_transmit), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        #2 reset = 1'b1;
        @(negedge clk);

        // All four requesting: full rotation starting at source 0
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant(40);
            check("t2_grant_order", 32'(grant), 32'(t2_order[g]));
            if (g == 4) req = '0;
            wait_end(200);
            if (g == 0) begin
                n = 0;
                @(negedge clk);
                while (active && !tx_transmit && n < 50) begin n++; @(negedge clk); end
                check("t2_gap_cycles", 32'(n), 32'd2);
                check("t2_idle_before_launch", 32'(active), 32'd0);
                @(negedge clk);
                check("t2_next_transmit", 32'(tx_transmit), 32'd1);
            end
        end
        wait_idle(20);

        // Single source, long frame
        bus_len = 110;
        req_data[7:0] = 8'hA5;
        r0 = rises;
        req = 4'b0001;
        wait_grant(20);
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_tx_data", 32'(tx_data), 32'hA5);
        repeat (50) @(negedge clk);
        check("t1_tx_data_mid", 32'(tx_data), 32'hA5);
        wait_end(300);
        check("t1_done", 32'(done), 32'h1);
        check("t1_single_edge", 32'(rises - r0), 32'd1);
        req = '0;
        bus_len = 12;
        wait_idle(20);

        // Pointer at 0: source 2 first, then 0; latched byte survives toggling
        req_data = {8'h44, 8'h22, 8'h00, 8'h11};
        req = 4'b0101;
        wait_grant(20);
        check("t3_first_grant", 32'(grant), 32'h4);
        check("t3_first_data", 32'(tx_data), 32'h22);
        req_data = {8'h44, 8'hEE, 8'h00, 8'h33};
        repeat (5) @(negedge clk);
        check("t3_data_held", 32'(tx_data), 32'h22);
        wait_end(100);
        check("t3_done2", 32'(done), 32'h4);
        req = 4'b0001;
        wait_grant(20);
        check("t3_second_grant", 32'(grant), 32'h1);
        check("t3_second_data", 32'(tx_data), 32'h33);
        wait_end(100);
        req = '0;
        wait_idle(20);

        // Transmitter never answers: 16-cycle launch, timeout, next source served
        bus_en = 1'b0;
        req = 4'b0011;
        wait_grant(20);
        check("t4_grant", 32'(grant), 32'h2);
        n = 0;
        while (tx_transmit && n < 100) begin n++; @(negedge clk); end
        check("t4_transmit_len", 32'(n), 32'd16);
        check("t4_timeout_err", 32'(timeout_err), 32'h2);
        check("t4_no_done", 32'(done), 32'd0);
        req = 4'b0001;
        bus_en = 1'b1;
        wait_grant(20);
        check("t4_next_grant", 32'(grant), 32'h1);
        wait_end(100);
        check("t4_next_done", 32'(done), 32'h1);
        req = '0;
        wait_idle(20);

        // Reset during SEND, then source 0 wins first
        req_data = {8'h44, 8'h77, 8'h00, 8'h33};
        req = 4'b0100;
        wait_grant(20);
        check("t5_grant", 32'(grant), 32'h4);
        wait_busy(20);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_grant", 32'(grant), 32'd0);
        check("t5_rst_transmit", 32'(tx_transmit), 32'd0);
        check("t5_rst_data", 32'(tx_data), 32'd0);
        check("t5_rst_active", 32'(active), 32'd0);
        check("t5_rst_done_err", 32'(done | timeout_err), 32'd0);
        req = 4'b0101;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        wait_grant(20);
        check("t5_after_reset_grant", 32'(grant), 32'h1);
        wait_end(100);
        req = 4'b0100;
        wait_grant(20);
        check("t5_then_grant", 32'(grant), 32'h4);
        wait_end(100);
        req = '0;
        wait_idle(20);

        // Request dropped mid-frame still completes with done
        req_data[15:8] = 8'h5A;
        req = 4'b0010;
        wait_grant(20);
        check("t6_grant", 32'(grant), 32'h2);
        wait_busy(20);
        repeat (2) @(negedge clk);
        req = '0;
        wait_end(100);
        check("t6_done", 32'(done), 32'h2);
        wait_idle(20);
        check("t6_idle_active", 32'(active), 32'd0);
        check("t6_idle_grant", 32'(grant), 32'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
